// File: rtl/blink_bank.sv
// blink_bank: one shared free-running tick counter driving CHANNELS LED outputs.
// Each channel has its own mode and rate. BURST mode exists only when BLINK_BANK_BURST_EN is defined.
module blink_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int RATE_W   = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [RATE_W-1:0]   cfg_rate,
  input  logic [3:0]          cfg_count,
  output logic [CNT_W-1:0]    tick_count,
  output logic [CHANNELS-1:0] blink_out,
  output logic [CHANNELS-1:0] busy
);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  logic [CNT_W-1:0]    tick_count_q, tick_count_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic [1:0]          mode_q [CHANNELS];
  logic [1:0]          mode_d [CHANNELS];
  logic [RATE_W-1:0]   rate_q [CHANNELS];
  logic [RATE_W-1:0]   rate_d [CHANNELS];
  logic [CHANNELS-1:0] phase_q, phase_d;
  logic [CHANNELS-1:0] blink_q, blink_d;
  logic [CHANNELS-1:0] tick_s;
  logic                accept_s;
  logic [1:0]          wr_mode_s;
  logic [RATE_W-1:0]   wr_rate_s;
`ifdef BLINK_BANK_BURST_EN
  logic [3:0]          remaining_q [CHANNELS];
  logic [3:0]          remaining_d [CHANNELS];
  logic [CHANNELS-1:0] busy_q, busy_d;
`else
  logic                unused_cfg_count;
  assign unused_cfg_count = ^cfg_count;
`endif

  // Ones in bits [r:0]; a channel ticks when the counter is all ones under this mask.
  function automatic logic [CNT_W-1:0] low_mask(input logic [RATE_W-1:0] r);
    logic [CNT_W-1:0] m;
    for (int i = 0; i < CNT_W; i++) begin
      m[i] = (i <= int'(r));
    end
    return m;
  endfunction

  function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] r);
    if (int'(r) >= CNT_W) begin
      return RATE_W'(CNT_W - 1);
    end else begin
      return r;
    end
  endfunction

  // Decode of the configuration request into the values a channel will load.
  always_comb begin
    accept_s  = cfg_valid & cfg_ready_q;
    wr_rate_s = clamp_rate(cfg_rate);
`ifdef BLINK_BANK_BURST_EN
    if ((cfg_mode == MODE_BURST) && (cfg_count == 4'd0)) begin
      wr_mode_s = MODE_OFF;
    end else begin
      wr_mode_s = cfg_mode;
    end
`else
    if (cfg_mode == MODE_BURST) begin
      wr_mode_s = MODE_BLINK;
    end else begin
      wr_mode_s = cfg_mode;
    end
`endif
  end

  // Shared counter and the one-cycle ready gap after each accept.
  always_comb begin
    if (ena) begin
      tick_count_d = tick_count_q + CNT_W'(1);
    end else begin
      tick_count_d = tick_count_q;
    end
    cfg_ready_d = ~accept_s;
  end

  // Per-channel next state; an accepted write overrides a same-cycle tick.
  always_comb begin
    mode_d  = mode_q;
    rate_d  = rate_q;
    phase_d = phase_q;
    blink_d = {CHANNELS{1'b0}};
    tick_s  = {CHANNELS{1'b0}};
`ifdef BLINK_BANK_BURST_EN
    remaining_d = remaining_q;
    busy_d      = {CHANNELS{1'b0}};
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      tick_s[c] = ena & (&(tick_count_q | ~low_mask(rate_q[c])));
      if (accept_s && (cfg_ch == CH_W'(c))) begin
        mode_d[c]  = wr_mode_s;
        rate_d[c]  = wr_rate_s;
        phase_d[c] = 1'b0;
`ifdef BLINK_BANK_BURST_EN
        remaining_d[c] = cfg_count;
`endif
      end else if (tick_s[c]) begin
        case (mode_q[c])
          MODE_BLINK: phase_d[c] = ~phase_q[c];
`ifdef BLINK_BANK_BURST_EN
          MODE_BURST: begin
            phase_d[c] = ~phase_q[c];
            // A falling toggle ends one pulse; the last one retires the burst.
            if (phase_q[c]) begin
              remaining_d[c] = remaining_q[c] - 4'd1;
              if (remaining_q[c] == 4'd1) begin
                mode_d[c] = MODE_OFF;
              end else begin
                mode_d[c] = mode_q[c];
              end
            end else begin
              remaining_d[c] = remaining_q[c];
            end
          end
`endif
          default: phase_d[c] = phase_q[c];
        endcase
      end else begin
        phase_d[c] = phase_q[c];
      end
      case (mode_d[c])
        MODE_ON:                blink_d[c] = 1'b1;
        MODE_BLINK, MODE_BURST: blink_d[c] = phase_d[c];
        default:                blink_d[c] = 1'b0;
      endcase
`ifdef BLINK_BANK_BURST_EN
      busy_d[c] = (mode_d[c] == MODE_BURST);
`endif
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_count_q <= {CNT_W{1'b0}};
      cfg_ready_q  <= 1'b1;
      mode_q       <= '{default: MODE_OFF};
      rate_q       <= '{default: {RATE_W{1'b0}}};
      phase_q      <= {CHANNELS{1'b0}};
      blink_q      <= {CHANNELS{1'b0}};
`ifdef BLINK_BANK_BURST_EN
      remaining_q  <= '{default: 4'd0};
      busy_q       <= {CHANNELS{1'b0}};
`endif
    end else begin
      tick_count_q <= tick_count_d;
      cfg_ready_q  <= cfg_ready_d;
      mode_q       <= mode_d;
      rate_q       <= rate_d;
      phase_q      <= phase_d;
      blink_q      <= blink_d;
`ifdef BLINK_BANK_BURST_EN
      remaining_q  <= remaining_d;
      busy_q       <= busy_d;
`endif
    end
  end

  assign tick_count = tick_count_q;
  assign cfg_ready  = cfg_ready_q;
  assign blink_out  = blink_q;
`ifdef BLINK_BANK_BURST_EN
  assign busy       = busy_q;
`else
  assign busy       = {CHANNELS{1'b0}};
`endif

endmodule
